rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/rr_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter.sv | 134 +++++++++++++
 tb/tb_rr_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned DefaultWidth   = 4;
  localparam int unsigned DefaultTimeout = 16;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-find-first: one-hot pick of the first set req bit at or after ptr.
module rr_pick #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PW    = 2
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [WIDTH-1:0] pick,
  output logic             found
);

  logic [PW:0] idx;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = {1'b0, ptr} + (PW+1)'(i);
      // Explicit compare-and-subtract keeps the wrap right for non-power-of-two WIDTH.
      if (idx >= (PW+1)'(WIDTH)) begin
        idx = idx - (PW+1)'(WIDTH);
      end
      if (!found && req[idx[PW-1:0]]) begin
        pick[idx[PW-1:0]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant and back-to-back handover.
// Optional grant-hold timeout enabled by defining RR_ARBITER_TIMEOUT_EN.
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = DefaultWidth,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             done,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic             any_req,
  output logic             timeout
);

  localparam int unsigned PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic             grant_valid_q;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    gnt_idx, ptr_inc, search_ptr;
  logic [WIDTH-1:0] pick;
  logic             found;
  logic             hold_hit;
  logic             release_now;

  rr_pick #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_pick (
    .req   (req),
    .ptr   (search_ptr),
    .pick  (pick),
    .found (found)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant_q[i]) begin
        gnt_idx = PW'(i);
      end
    end
  end

  assign ptr_inc    = (gnt_idx == PW'(WIDTH - 1)) ? '0 : gnt_idx + PW'(1);
  // In BUSY the search only matters on release, which always starts after the holder.
  assign search_ptr = (state_q == StBusy) ? ptr_inc : ptr_q;
  assign release_now = (state_q == StBusy) && (done || !(|(req & grant_q)) || hold_hit);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (release_now) begin
          ptr_d   = ptr_inc;
          grant_d = found ? pick : '0;
          state_d = found ? StBusy : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_valid_q <= |grant_d;
      ptr_q         <= ptr_d;
    end
  end

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          timeout_q;

  // Count value is the number of BUSY cycles already completed under the current grant.
  assign hold_hit = (state_q == StBusy) && (hold_cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d == StBusy && (state_q == StIdle || release_now)) begin
      hold_cnt_d = '0;
    end else if (state_q == StBusy) begin
      hold_cnt_d = hold_cnt_q + CW'(1);
    end else begin
      hold_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= hold_hit;
    end
  end

  assign timeout = timeout_q;
`else
  assign hold_hit = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign any_req     = |req;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed self-checking bench for rr_arbiter (WIDTH=4, TIMEOUT=16).
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic       any_req;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  rr_arbiter #(
    .WIDTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .any_req     (any_req),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] rot_exp [4];

  initial begin
    rot_exp[0] = 4'b0010;
    rot_exp[1] = 4'b0100;
    rot_exp[2] = 4'b1000;
    rot_exp[3] = 4'b0001;

    rst = 1'b1; req = 4'b1111; done = 1'b0;
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_gv", 32'(grant_valid), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    check("any_req_hi", 32'(any_req), 32'h1);

    rst = 1'b0;
    step();
    check("first_grant", 32'(grant), 32'h1);
    check("first_gv", 32'(grant_valid), 32'h1);

    // done every third cycle rotates the grant with no bubble
    for (int k = 0; k < 4; k++) begin
      step();
      check("rot_hold_a", 32'(grant), 32'(rot_exp[(k + 3) % 4]));
      step();
      check("rot_hold_b", 32'(grant), 32'(rot_exp[(k + 3) % 4]));
      done = 1'b1;
      step();
      done = 1'b0;
      check("rot_switch", 32'(grant), 32'(rot_exp[k]));
      check("rot_gv", 32'(grant_valid), 32'h1);
    end

    // grant 0010, then release with req 0011 -> search from 2 wraps to 0
    done = 1'b1;
    step();
    check("to_0010", 32'(grant), 32'h2);
    req = 4'b0011;
    step();
    done = 1'b0;
    check("wrap_0001", 32'(grant), 32'h1);

    // move grant to bit 2 (ptr=1 after release of 0), then holder drops req
    req = 4'b0101; done = 1'b1;
    step();
    done = 1'b0;
    check("to_0100", 32'(grant), 32'h4);
    req = 4'b1001;
    step();
    check("drop_to_1000", 32'(grant), 32'h8);
    req = 4'b0000;
    step();
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_gv", 32'(grant_valid), 32'h0);
    check("any_req_lo", 32'(any_req), 32'h0);

    done = 1'b1;
    step();
    done = 1'b0;
    check("done_in_idle", 32'(grant), 32'h0);

    // build ptr=2 with grant 0100, then reset must clear ptr
    req = 4'b0010;
    step();
    check("grant_0010", 32'(grant), 32'h2);
    req = 4'b0100;
    step();
    check("grant_0100", 32'(grant), 32'h4);
    rst = 1'b1; req = 4'b0110;
    step();
    check("midbusy_rst", 32'(grant), 32'h0);
    check("midbusy_rst_gv", 32'(grant_valid), 32'h0);
    rst = 1'b0;
    step();
    check("post_rst_ptr0", 32'(grant), 32'h2);

    // other req bits toggling must not disturb the holder
    req = 4'b1111;
    step();
    check("nongrant_chg_a", 32'(grant), 32'h2);
    req = 4'b0010;
    step();
    check("nongrant_chg_b", 32'(grant), 32'h2);

    // reset dominates done and req
    rst = 1'b1; done = 1'b1; req = 4'b1111;
    step();
    check("rst_dominates", 32'(grant), 32'h0);
    rst = 1'b0; done = 1'b0; req = 4'b0001;
    step();
    check("single_grant", 32'(grant), 32'h1);

`ifdef RR_ARBITER_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      step();
      check("to_hold", 32'(grant), 32'h1);
      check("to_quiet", 32'(timeout), 32'h0);
    end
    step();
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_regrant", 32'(grant), 32'h1);
    check("to_regrant_gv", 32'(grant_valid), 32'h1);
    step();
    check("to_pulse_end", 32'(timeout), 32'h0);
`else
    for (int k = 1; k < 24; k++) begin
      step();
      if (k % 8 == 0) begin
        check("hold_forever", 32'(grant), 32'h1);
        check("timeout_tied", 32'(timeout), 32'h0);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
